chan_swap_bank: RTL and testbench

CHAN_SWAP_BANK -- requirements
Module: chan_swap_bank

---
 rtl/chan_swap_pkg.sv | 28 ++
 rtl/chan_swap_reg.sv | 42 ++++
 rtl/chan_swap_bank.sv | 153 +++++++++++++++
 tb/tb_chan_swap_bank.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/chan_swap_pkg.sv
// Shared operation and state encodings for the A/B channel swap bank.
package chan_swap_pkg;

   typedef enum logic [2:0] {
      OP_LOAD_A  = 3'd0,
      OP_LOAD_B  = 3'd1,
      OP_COPY_AB = 3'd2,
      OP_COPY_BA = 3'd3,
      OP_SWAP    = 3'd4,
      OP_READ    = 3'd5
   } op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } state_e;

   localparam int        OP_W        = 3;
   localparam int        CHAN_W      = 4;
   localparam logic [7:0] ERR_CNT_MAX = 8'hFF;

   // Codes 6 and 7 are reserved and rejected.
   function automatic logic op_legal(input logic [OP_W-1:0] op);
      return op <= 3'(OP_READ);
   endfunction

endpackage

// File: rtl/chan_swap_reg.sv
// One A/B register pair; at most one write enable is active per clock.
module chan_swap_reg #(
   parameter int               WIDTH     = 8,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             sysclk,
   input  logic             rst_n,
   input  logic             we_load_a,
   input  logic             we_load_b,
   input  logic             we_copy_ab,
   input  logic             we_copy_ba,
   input  logic             we_swap,
   input  logic [WIDTH-1:0] data,
   output logic [WIDTH-1:0] a,
   output logic [WIDTH-1:0] b
);

   logic [WIDTH-1:0] a_reg;
   logic [WIDTH-1:0] b_reg;

   always_ff @(posedge sysclk or negedge rst_n) begin
      if (!rst_n) begin
         a_reg <= RESET_VAL;
         b_reg <= RESET_VAL;
      end else if (we_load_a) begin
         a_reg <= data;
      end else if (we_load_b) begin
         b_reg <= data;
      end else if (we_copy_ab) begin
         b_reg <= a_reg;
      end else if (we_copy_ba) begin
         a_reg <= b_reg;
      end else if (we_swap) begin
         a_reg <= b_reg;
         b_reg <= a_reg;
      end
   end

   assign a = a_reg;
   assign b = b_reg;

endmodule

// File: rtl/chan_swap_bank.sv
// Bank of CHANNELS A/B register pairs driven by a one-command-at-a-time
// IDLE -> EXEC -> RESP handshake controller.
module chan_swap_bank
   import chan_swap_pkg::*;
#(
   parameter int               WIDTH     = 8,
   parameter int               CHANNELS  = 4,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             sysclk,
   input  logic             rst_n,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [2:0]       cmd_op,
   input  logic [3:0]       cmd_chan,
   input  logic [WIDTH-1:0] cmd_data,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [WIDTH-1:0] rsp_a,
   output logic [WIDTH-1:0] rsp_b,
   output logic             rsp_err,
   output logic [7:0]       err_cnt
);

   localparam logic [CHAN_W:0] CHAN_LIM = (CHAN_W + 1)'(CHANNELS);

   state_e              state_reg;
   logic [OP_W-1:0]     op_reg;
   logic [CHAN_W-1:0]   chan_reg;
   logic [WIDTH-1:0]    data_reg;
   logic                rsp_valid_reg;
   logic [WIDTH-1:0]    rsp_a_reg;
   logic [WIDTH-1:0]    rsp_b_reg;
   logic                rsp_err_reg;
   logic [7:0]          err_cnt_reg;

   logic [WIDTH-1:0]    a_vec [CHANNELS];
   logic [WIDTH-1:0]    b_vec [CHANNELS];
   logic [WIDTH-1:0]    cur_a;
   logic [WIDTH-1:0]    cur_b;
   logic [WIDTH-1:0]    post_a;
   logic [WIDTH-1:0]    post_b;
   logic                cmd_bad;
   logic                exec_ok;

   assign cmd_bad = !op_legal(op_reg) || ({1'b0, chan_reg} >= CHAN_LIM);
   assign exec_ok = (state_reg == ST_EXEC) && !cmd_bad;

   // Out-of-range channels fall through to zero; they are rejected anyway.
   always_comb begin
      cur_a = '0;
      cur_b = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         if (chan_reg == CHAN_W'(i)) begin
            cur_a = a_vec[i];
            cur_b = b_vec[i];
         end
      end
   end

   // Value the target pair will hold after the EXEC edge.
   always_comb begin
      post_a = cur_a;
      post_b = cur_b;
      case (op_reg)
         OP_LOAD_A:  post_a = data_reg;
         OP_LOAD_B:  post_b = data_reg;
         OP_COPY_AB: post_b = cur_a;
         OP_COPY_BA: post_a = cur_b;
         OP_SWAP: begin
            post_a = cur_b;
            post_b = cur_a;
         end
         default: ;
      endcase
   end

   generate
      for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
         logic hit;
         assign hit = exec_ok && (chan_reg == CHAN_W'(gi));

         chan_swap_reg #(
            .WIDTH     (WIDTH),
            .RESET_VAL (RESET_VAL)
         ) u_reg (
            .sysclk     (sysclk),
            .rst_n      (rst_n),
            .we_load_a  (hit && (op_reg == OP_LOAD_A)),
            .we_load_b  (hit && (op_reg == OP_LOAD_B)),
            .we_copy_ab (hit && (op_reg == OP_COPY_AB)),
            .we_copy_ba (hit && (op_reg == OP_COPY_BA)),
            .we_swap    (hit && (op_reg == OP_SWAP)),
            .data       (data_reg),
            .a          (a_vec[gi]),
            .b          (b_vec[gi])
         );
      end
   endgenerate

   always_ff @(posedge sysclk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg     <= ST_IDLE;
         op_reg        <= '0;
         chan_reg      <= '0;
         data_reg      <= '0;
         rsp_valid_reg <= 1'b0;
         rsp_a_reg     <= '0;
         rsp_b_reg     <= '0;
         rsp_err_reg   <= 1'b0;
         err_cnt_reg   <= '0;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               if (cmd_valid) begin
                  op_reg    <= cmd_op;
                  chan_reg  <= cmd_chan;
                  data_reg  <= cmd_data;
                  state_reg <= ST_EXEC;
               end
            end
            ST_EXEC: begin
               rsp_valid_reg <= 1'b1;
               rsp_err_reg   <= cmd_bad;
               rsp_a_reg     <= cmd_bad ? '0 : post_a;
               rsp_b_reg     <= cmd_bad ? '0 : post_b;
               if (cmd_bad && (err_cnt_reg != ERR_CNT_MAX)) begin
                  err_cnt_reg <= err_cnt_reg + 8'd1;
               end
               state_reg <= ST_RESP;
            end
            ST_RESP: begin
               if (rsp_ready) begin
                  rsp_valid_reg <= 1'b0;
                  rsp_err_reg   <= 1'b0;
                  rsp_a_reg     <= '0;
                  rsp_b_reg     <= '0;
                  state_reg     <= ST_IDLE;
               end
            end
            default: state_reg <= ST_IDLE;
         endcase
      end
   end

   assign cmd_ready = (state_reg == ST_IDLE);
   assign rsp_valid = rsp_valid_reg;
   assign rsp_a     = rsp_a_reg;
   assign rsp_b     = rsp_b_reg;
   assign rsp_err   = rsp_err_reg;
   assign err_cnt   = err_cnt_reg;

endmodule

// File: tb/tb_chan_swap_bank.sv
// Bench for chan_swap_bank: directed vector table, stall/reset sequences and
// random commands checked against an array-based reference model.
module tb_chan_swap_bank;
   import chan_swap_pkg::*;

   localparam int W  = 8;
   localparam int CH = 4;

   logic         sysclk = 1'b0;
   logic         rst_n = 1'b0;
   logic         cmd_valid = 1'b0;
   logic         cmd_ready;
   logic [2:0]   cmd_op = 3'd0;
   logic [3:0]   cmd_chan = 4'd0;
   logic [W-1:0] cmd_data = '0;
   logic         rsp_valid;
   logic         rsp_ready = 1'b1;
   logic [W-1:0] rsp_a;
   logic [W-1:0] rsp_b;
   logic         rsp_err;
   logic [7:0]   err_cnt;

   chan_swap_bank #(.WIDTH(W), .CHANNELS(CH), .RESET_VAL('0)) dut (
      .sysclk    (sysclk),
      .rst_n     (rst_n),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_op    (cmd_op),
      .cmd_chan  (cmd_chan),
      .cmd_data  (cmd_data),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_a     (rsp_a),
      .rsp_b     (rsp_b),
      .rsp_err   (rsp_err),
      .err_cnt   (err_cnt)
   );

   always #5 sysclk = ~sysclk;

   int n_cmp  = 0;
   int n_fail = 0;

   // Reference model: the bank contents and the rejected-command count.
   logic [W-1:0] ma [CH];
   logic [W-1:0] mb [CH];
   int           merr;

   typedef struct {
      logic [2:0]   op;
      logic [3:0]   ch;
      logic [W-1:0] d;
      logic [W-1:0] ea;
      logic [W-1:0] eb;
      logic         ee;
   } vec_t;
   vec_t tbl [13];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h @%0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < CH; i++) begin
         ma[i] = '0;
         mb[i] = '0;
      end
      merr = 0;
   endtask

   task automatic model_cmd(input int op, input int ch, input logic [W-1:0] d,
                            output logic [W-1:0] ea, output logic [W-1:0] eb, output logic ee);
      logic [W-1:0] t;
      if (ch >= CH || op > 5) begin
         ee = 1'b1;
         ea = '0;
         eb = '0;
         if (merr < 255) merr = merr + 1;
      end else begin
         case (op)
            0: ma[ch] = d;
            1: mb[ch] = d;
            2: mb[ch] = ma[ch];
            3: ma[ch] = mb[ch];
            4: begin t = ma[ch]; ma[ch] = mb[ch]; mb[ch] = t; end
            default: ;
         endcase
         ee = 1'b0;
         ea = ma[ch];
         eb = mb[ch];
      end
   endtask

   // Full command: offer, check latency, compare against model, optionally stall.
   task automatic send(input logic [2:0] op, input logic [3:0] ch, input logic [W-1:0] d,
                       input int hold, output logic [W-1:0] ga, output logic [W-1:0] gb,
                       output logic ge);
      logic [W-1:0] ea, eb;
      logic         ee;
      int           n = 0;
      while (!cmd_ready && n < 20) begin
         @(posedge sysclk); #1;
         n++;
      end
      chk("cmd_ready_idle", 32'(cmd_ready), 32'd1);
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_chan  = ch;
      cmd_data  = d;
      @(posedge sysclk); #1;
      cmd_valid = 1'b0;
      if (hold > 0) rsp_ready = 1'b0;
      chk("exec_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("exec_cmd_ready", 32'(cmd_ready), 32'd0);
      @(posedge sysclk); #1;
      chk("latency_rsp_valid", 32'(rsp_valid), 32'd1);
      ga = rsp_a;
      gb = rsp_b;
      ge = rsp_err;
      model_cmd(int'(op), int'(ch), d, ea, eb, ee);
      chk("model_rsp_a", 32'(rsp_a), 32'(ea));
      chk("model_rsp_b", 32'(rsp_b), 32'(eb));
      chk("model_rsp_err", 32'(rsp_err), 32'(ee));
      chk("model_err_cnt", 32'(err_cnt), 32'(merr));
      for (int k = 0; k < hold; k++) begin
         cmd_valid = 1'b1;
         cmd_op    = 3'd0;
         cmd_chan  = 4'd0;
         cmd_data  = 8'h5A;
         @(posedge sysclk); #1;
         chk("stall_rsp_valid", 32'(rsp_valid), 32'd1);
         chk("stall_cmd_ready", 32'(cmd_ready), 32'd0);
         chk("stall_rsp_stable", {15'd0, rsp_err, rsp_a, rsp_b}, {15'd0, ge, ga, gb});
      end
      cmd_valid = 1'b0;
      rsp_ready = 1'b1;
      @(posedge sysclk); #1;
      chk("post_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("post_rsp_zero", {15'd0, rsp_err, rsp_a, rsp_b}, 32'd0);
   endtask

   initial begin
      logic [W-1:0] ga, gb;
      logic         ge;

      tbl[0]  = '{3'd0, 4'd1, 8'h3C, 8'h3C, 8'h00, 1'b0}; // LOAD_A ch1
      tbl[1]  = '{3'd5, 4'd1, 8'h00, 8'h3C, 8'h00, 1'b0}; // READ ch1
      tbl[2]  = '{3'd0, 4'd2, 8'h11, 8'h11, 8'h00, 1'b0}; // LOAD_A ch2
      tbl[3]  = '{3'd1, 4'd2, 8'h22, 8'h11, 8'h22, 1'b0}; // LOAD_B ch2
      tbl[4]  = '{3'd4, 4'd2, 8'h00, 8'h22, 8'h11, 1'b0}; // SWAP ch2
      tbl[5]  = '{3'd5, 4'd0, 8'h00, 8'h00, 8'h00, 1'b0}; // READ ch0
      tbl[6]  = '{3'd5, 4'd1, 8'h00, 8'h3C, 8'h00, 1'b0}; // READ ch1
      tbl[7]  = '{3'd5, 4'd3, 8'h00, 8'h00, 8'h00, 1'b0}; // READ ch3
      tbl[8]  = '{3'd0, 4'd0, 8'hA5, 8'hA5, 8'h00, 1'b0}; // LOAD_A ch0
      tbl[9]  = '{3'd2, 4'd0, 8'h00, 8'hA5, 8'hA5, 1'b0}; // COPY_AB ch0
      tbl[10] = '{3'd3, 4'd0, 8'h00, 8'hA5, 8'hA5, 1'b0}; // COPY_BA ch0
      tbl[11] = '{3'd5, 4'd4, 8'h00, 8'h00, 8'h00, 1'b1}; // bad channel
      tbl[12] = '{3'd7, 4'd0, 8'h77, 8'h00, 8'h00, 1'b1}; // illegal op

      model_reset();
      rst_n = 1'b0;
      repeat (3) @(posedge sysclk);
      #1;
      chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("reset_rsp_zero", {15'd0, rsp_err, rsp_a, rsp_b}, 32'd0);
      chk("reset_err_cnt", 32'(err_cnt), 32'd0);
      rst_n = 1'b1;
      @(posedge sysclk); #1;
      chk("reset_cmd_ready", 32'(cmd_ready), 32'd1);

      for (int i = 0; i < 13; i++) begin
         send(tbl[i].op, tbl[i].ch, tbl[i].d, 0, ga, gb, ge);
         chk($sformatf("vec%0d_a", i), 32'(ga), 32'(tbl[i].ea));
         chk($sformatf("vec%0d_b", i), 32'(gb), 32'(tbl[i].eb));
         chk($sformatf("vec%0d_err", i), 32'(ge), 32'(tbl[i].ee));
      end
      chk("err_cnt_two", 32'(err_cnt), 32'd2);
      send(3'd5, 4'd2, 8'h00, 0, ga, gb, ge);
      chk("ch2_after_errors", {16'd0, ga, gb}, 32'h2211);

      // Back-pressure: the stalled LOAD_A ch0 0x5A offers must not be taken.
      send(3'd1, 4'd3, 8'h77, 5, ga, gb, ge);
      send(3'd5, 4'd0, 8'h00, 0, ga, gb, ge);
      chk("stall_no_accept", 32'(ga), 32'hA5);

      for (int i = 0; i < 150; i++) begin
         send(3'($urandom_range(0, 7)), 4'($urandom_range(0, 5)), 8'($urandom),
              int'($urandom_range(0, 2)), ga, gb, ge);
      end

      for (int i = 0; i < 300; i++) begin
         send(3'd6, 4'd0, 8'h00, 0, ga, gb, ge);
      end
      chk("err_cnt_saturate", 32'(err_cnt), 32'd255);

      // Reset while a LOAD_A 0xFF response is pending.
      cmd_valid = 1'b1;
      cmd_op    = 3'd0;
      cmd_chan  = 4'd1;
      cmd_data  = 8'hFF;
      @(posedge sysclk); #1;
      cmd_valid = 1'b0;
      rsp_ready = 1'b0;
      @(posedge sysclk); #1;
      chk("pre_reset_rsp", {23'd0, rsp_valid, rsp_a}, 32'h1FF);
      rst_n = 1'b0;
      #1;
      chk("async_rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("async_rst_rsp_a", 32'(rsp_a), 32'd0);
      chk("async_rst_cmd_ready", 32'(cmd_ready), 32'd1);
      chk("async_rst_err_cnt", 32'(err_cnt), 32'd0);
      @(posedge sysclk); #1;
      rst_n = 1'b1;
      rsp_ready = 1'b1;
      model_reset();
      for (int c = 0; c < CH; c++) begin
         send(3'd5, 4'(c), 8'h00, 0, ga, gb, ge);
         chk($sformatf("post_reset_ch%0d", c), {16'd0, ga, gb}, 32'd0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
